// File: rtl/regfile_pkg.sv
// Shared widths and constants for the MIPS general-purpose register file.
package regfile_pkg;
   localparam int RegAddrBus = 5;
   localparam int RegDataBus = 32;
   localparam int NUM_REGS   = 32;

   localparam logic [RegAddrBus-1:0] RegAddr_0 = '0;
   localparam logic [RegDataBus-1:0] ZeroWord  = '0;
   localparam logic                  Enable    = 1'b1;
   localparam logic                  Disable   = 1'b0;
endpackage

// File: rtl/regfile_if.sv
// Decode/write-back/debug bus into the register file.
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = RegDataBus,
   parameter int ADDR_W = RegAddrBus
);
   logic              we_i;
   logic [ADDR_W-1:0] waddr_i;
   logic [DATA_W-1:0] wdata_i;
   logic              re1_i;
   logic [ADDR_W-1:0] raddr1_i;
   logic [DATA_W-1:0] rdata1_o;
   logic              re2_i;
   logic [ADDR_W-1:0] raddr2_i;
   logic [DATA_W-1:0] rdata2_o;
   logic              dbg_req_i;
   logic [ADDR_W-1:0] dbg_addr_i;
   logic              dbg_valid_o;
   logic [DATA_W-1:0] dbg_data_o;

   modport master (
      output we_i, waddr_i, wdata_i, re1_i, raddr1_i, re2_i, raddr2_i,
             dbg_req_i, dbg_addr_i,
      input  rdata1_o, rdata2_o, dbg_valid_o, dbg_data_o
   );

   modport slave (
      input  we_i, waddr_i, wdata_i, re1_i, raddr1_i, re2_i, raddr2_i,
             dbg_req_i, dbg_addr_i,
      output rdata1_o, rdata2_o, dbg_valid_o, dbg_data_o
   );
endinterface

// File: rtl/regfile_rport.sv
// One combinational read port: reset/enable/zero-register gating, then
// same-cycle write bypass, then storage.
module regfile_rport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RegDataBus,
   parameter int ADDR_W   = RegAddrBus,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
   input  logic                             rst,
   input  logic                             re,
   input  logic [ADDR_W-1:0]                raddr,
   input  logic                             we,
   input  logic [ADDR_W-1:0]                waddr,
   input  logic [DATA_W-1:0]                wdata,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
   output logic [DATA_W-1:0]                rdata
);
   // re is tested first so an X address behind a disabled port still yields 0
   always_comb begin
      rdata = '0;
      if (!rst || re == Disable || raddr == '0)
         rdata = '0;
      else if (we == Enable && raddr == waddr)
         rdata = wdata;
      else
         rdata = regs[raddr];
   end
endmodule

// File: rtl/regfile.sv
// 32 x 32 MIPS register file: two combinational read ports with write
// bypass, synchronous write, and a registered debug read port.
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RegDataBus,
   parameter int ADDR_W   = RegAddrBus,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
   input  logic       clk,
   input  logic       rst,
   regfile_if.slave   bus
);
   logic [DATA_W-1:0]               mem [1:NUM_REGS-1];
   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [DATA_W-1:0]               dbg_rd;
   logic                            dbg_vld;
   logic [DATA_W-1:0]               dbg_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < NUM_REGS; i++) mem[i] <= '0;
      end else if (bus.we_i == Enable && bus.waddr_i != '0) begin
         mem[bus.waddr_i] <= bus.wdata_i;
      end
   end

   // Entry 0 has no storage; the flat view feeds all three read muxes
   always_comb begin
      regs[0] = '0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] = mem[i];
   end

   regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rport1 (
      .rst(rst), .re(bus.re1_i), .raddr(bus.raddr1_i),
      .we(bus.we_i), .waddr(bus.waddr_i), .wdata(bus.wdata_i),
      .regs(regs), .rdata(bus.rdata1_o)
   );

   regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rport2 (
      .rst(rst), .re(bus.re2_i), .raddr(bus.raddr2_i),
      .we(bus.we_i), .waddr(bus.waddr_i), .wdata(bus.wdata_i),
      .regs(regs), .rdata(bus.rdata2_o)
   );

   regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rport_dbg (
      .rst(rst), .re(Enable), .raddr(bus.dbg_addr_i),
      .we(bus.we_i), .waddr(bus.waddr_i), .wdata(bus.wdata_i),
      .regs(regs), .rdata(dbg_rd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dbg_vld  <= 1'b0;
         dbg_data <= '0;
      end else begin
         dbg_vld <= bus.dbg_req_i;
         if (bus.dbg_req_i) dbg_data <= dbg_rd;
      end
   end

   assign bus.dbg_valid_o = dbg_vld;
   assign bus.dbg_data_o  = dbg_data;
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Responder for the decode stage's two register-read requests; the write-back stage writes it.
- Reads are combinational, so decode gets operands in the same cycle it issues the address.
- Write is synchronous, with a write-to-read bypass so decode never sees stale data for a register being written back that cycle.
- A registered debug read port gives the testbench and trace logic visibility without disturbing the pipeline.

Parameters:
- DATA_W, 32, register width (matches RegDataBus).
- ADDR_W, 5, register address width (matches RegAddrBus).
- NUM_REGS, 32, number of architectural registers; entry 0 is hardwired to zero.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; asserts immediately, deassertion is synchronised externally.
- we_i  in  1  write enable from write-back.
- waddr_i  in  ADDR_W  write address.
- wdata_i  in  DATA_W  write data.
- re1_i  in  1  read enable, port 1.
- raddr1_i  in  ADDR_W  read address, port 1.
- rdata1_o  out  DATA_W  read data, port 1 (combinational).
- re2_i  in  1  read enable, port 2.
- raddr2_i  in  ADDR_W  read address, port 2.
- rdata2_o  out  DATA_W  read data, port 2 (combinational).
- dbg_req_i  in  1  debug read request.
- dbg_addr_i  in  ADDR_W  debug read address.
- dbg_valid_o  out  1  debug data valid, one cycle after the request.
- dbg_data_o  out  DATA_W  registered debug read data.

Behaviour:
- Reset (rst==0): all registers 1..31 clear to 0 asynchronously; dbg_valid_o=0 and dbg_data_o=0. rdata1_o and rdata2_o are forced to 0 while rst==0, regardless of re/raddr.
- Write: at the rising clk, if we_i==1 and waddr_i!=0, regs[waddr_i] <= wdata_i. Writes to address 0 are discarded.
- Read port n, in priority order:
  - re==0 gives 0.
  - raddr==0 gives 0.
  - re==1, we_i==1 and raddr==waddr_i gives wdata_i (same-cycle bypass).
  - Otherwise gives regs[raddr].
- Both read ports may target the same address, including the one being written; both must return identical values.
- Bypass is purely combinational from we_i/waddr_i/wdata_i. There are no cycles of latency on the read path.
- Debug port:
  - dbg_req_i sampled at a rising edge sets dbg_valid_o=1 for exactly the next cycle.
  - dbg_data_o captures the value port 1 would return for dbg_addr_i with re=1, including the bypass. A simultaneous write to the same address therefore returns the new data.
  - Back-to-back requests produce back-to-back valid cycles.
  - Without a request, dbg_valid_o=0 and dbg_data_o holds its last value.
- Reset mid-operation: a write in the same cycle rst falls is lost. Registers read 0 from reset assertion onward. A pending dbg_valid_o is cleared immediately.
- X-safety: an address with X while re==0 must still yield 0 output.

Decomposition:
- Shared package/define header holds:
  - RegAddrBus and RegDataBus widths.
  - RegAddr_0, ZeroWord, Enable/Disable constants.
  - NUM_REGS.
- No sub-module for storage.
- One natural sub-module, regfile_rport: the combinational read-mux with bypass and zero rules. It is instantiated three times (port 1, port 2, debug capture path), so the priority rules are defined once.

Test Plan:
- Reset then read: rst=0 then 1; re1_i=1 raddr1_i=5, re2_i=1 raddr2_i=31 -> rdata1_o=0, rdata2_o=0.
- Write then read: cycle 0 we_i=1 waddr_i=3 wdata_i=32'h1234_5678. Cycle 1 we_i=0, re1_i=1 raddr1_i=3 -> rdata1_o=32'h1234_5678.
- Same-cycle bypass: regs[7]=32'hAAAA_AAAA; we_i=1 waddr_i=7 wdata_i=32'h5555_5555, re1_i=re2_i=1 raddr1_i=raddr2_i=7 -> both outputs 32'h5555_5555 in the same cycle. Next cycle, with no write -> both still 32'h5555_5555.
- Register 0 immutable: we_i=1 waddr_i=0 wdata_i=32'hFFFF_FFFF. Same cycle and next, re1_i=1 raddr1_i=0 -> rdata1_o=0.
- Read enable gating: regs[9]=32'hDEAD_BEEF; re2_i=0 raddr2_i=9 -> rdata2_o=0. Set re2_i=1 -> 32'hDEAD_BEEF.
- Debug and async reset:
  - regs[4]=32'h0000_00FF; dbg_req_i=1 dbg_addr_i=4 for two cycles -> dbg_valid_o=1 for two cycles, dbg_data_o=32'h0000_00FF.
  - Assert rst=0 mid-clock-period -> dbg_valid_o=0, dbg_data_o=0 and regs[4] reads 0 without waiting for a clock edge.
